// File: rtl/psx_ddr_mem_responder.sv
// Avalon-MM-style 64-bit burst memory responder standing in for the PSX GPU bridge DDR controller.
// Optional pseudo-random waitrequest stalls are enabled by defining PSX_DDR_RESP_STALL_EN.
module psx_ddr_mem_responder #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_nRst,
  input  logic [ADDR_W-1:0] i_targetAddr,
  input  logic [2:0]        i_burstLength,
  input  logic              i_readEnable,
  input  logic              i_writeEnable,
  input  logic [63:0]       i_data,
  input  logic [7:0]        i_byteEnable,
  output logic              o_busy,
  output logic              o_dataValid,
  output logic [63:0]       o_data,
  output logic              o_protocolError
);

  localparam int unsigned            DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]      ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE_BURST,
    S_READ_ISSUE,
    S_READ_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          len_q, len_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] vld_rest;
  logic [63:0]             data_q [READ_LATENCY];
  logic [63:0]             mem_q  [DEPTH];

  logic              stall;
  logic              accept;
  logic              issue;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        len_eff;
  logic              len_legal;

`ifdef PSX_DDR_RESP_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b11);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    len_eff   = i_burstLength;
    len_legal = 1'b1;
    if (i_burstLength == 3'd0) begin
      len_eff   = 3'd1;
      len_legal = 1'b0;
    end else if (i_burstLength > 3'd4) begin
      len_eff   = 3'd4;
      len_legal = 1'b0;
    end
  end

  always_comb begin
    o_busy = 1'b0;
    if (state_q == S_READ_ISSUE || state_q == S_READ_DRAIN) begin
      o_busy = 1'b1;
    end else begin
      o_busy = stall;
    end
  end

  assign accept = !o_busy && (i_readEnable || i_writeEnable);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    wr_addr  = addr_q;
    issue    = 1'b0;
    vld_rest = vld_q;
    vld_rest[READ_LATENCY-1] = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d = len_eff;
          if (!len_legal) err_d = 1'b1;
          if (i_writeEnable) begin
            // Write wins a simultaneous read request; the read is dropped.
            if (i_readEnable) err_d = 1'b1;
            wr_en   = 1'b1;
            wr_addr = i_targetAddr;
            addr_d  = i_targetAddr + ADDR_ONE;
            cnt_d   = 3'd1;
            if (len_eff != 3'd1) state_d = S_WRITE_BURST;
          end else begin
            addr_d  = i_targetAddr;
            cnt_d   = 3'd0;
            state_d = S_READ_ISSUE;
          end
        end
      end
      S_WRITE_BURST: begin
        if (i_readEnable) err_d = 1'b1;
        if (!o_busy && i_writeEnable) begin
          wr_en  = 1'b1;
          addr_d = addr_q + ADDR_ONE;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == len_q - 3'd1) state_d = S_IDLE;
        end
      end
      S_READ_ISSUE: begin
        issue  = 1'b1;
        addr_d = addr_q + ADDR_ONE;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == len_q - 3'd1) state_d = S_READ_DRAIN;
      end
      S_READ_DRAIN: begin
        // Beats are contiguous, so the last one is at the output with nothing behind it.
        if (vld_q[READ_LATENCY-1] && vld_rest == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= 3'd1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= issue;
      if (issue) data_q[0] <= mem_q[addr_q];
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (i_byteEnable[b]) mem_q[wr_addr][8*b +: 8] <= i_data[8*b +: 8];
      end
    end
  end

  assign o_dataValid     = vld_q[READ_LATENCY-1];
  assign o_data          = data_q[READ_LATENCY-1];
  assign o_protocolError = err_q;

endmodule

// File: tb/tb_psx_ddr_mem_responder.sv
// Scoreboard bench for psx_ddr_mem_responder: directed commands push expected beats, a monitor checks them.
module tb_psx_ddr_mem_responder;
  localparam int unsigned RL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] i_targetAddr = '0;
  logic [2:0]  i_burstLength = 3'd1;
  logic        i_readEnable = 1'b0;
  logic        i_writeEnable = 1'b0;
  logic [63:0] i_data = '0;
  logic [7:0]  i_byteEnable = '0;
  logic        o_busy, o_dataValid, o_protocolError;
  logic [63:0] o_data;

  psx_ddr_mem_responder #(.ADDR_W(17), .READ_LATENCY(RL)) dut (
    .i_clk(clk), .i_nRst(rst_n), .i_targetAddr(i_targetAddr), .i_burstLength(i_burstLength),
    .i_readEnable(i_readEnable), .i_writeEnable(i_writeEnable), .i_data(i_data),
    .i_byteEnable(i_byteEnable), .o_busy(o_busy), .o_dataValid(o_dataValid),
    .o_data(o_data), .o_protocolError(o_protocolError)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] d; int unsigned c; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] D0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D2 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] D3 = 64'hDDDD_EEEE_FFFF_0000;
  localparam logic [63:0] DS = 64'h0123_4567_89AB_CDEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_dataValid) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", {63'b0, o_dataValid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("read_data", o_data, e.d);
        check("beat_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  function automatic int unsigned eff_len(input logic [2:0] bl);
    if (bl == 3'd0) return 1;
    if (bl > 3'd4) return 4;
    return int'(bl);
  endfunction

  task automatic wait_accept(output int unsigned acc, output bit ok);
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        acc = cyc;
        ok  = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic wbeat(input logic [16:0] a, input logic [2:0] bl, input logic [63:0] d,
                       input logic [7:0] be, input logic re);
    int unsigned acc;
    bit ok;
    i_targetAddr = a; i_burstLength = bl; i_data = d; i_byteEnable = be;
    i_writeEnable = 1'b1; i_readEnable = re;
    wait_accept(acc, ok);
    i_writeEnable = 1'b0; i_readEnable = 1'b0;
  endtask

  task automatic rd(input logic [16:0] a, input logic [2:0] bl, input logic [63:0] d0,
                    input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3);
    int unsigned acc, len, tgt;
    bit ok;
    logic [63:0] dv [4];
    dv = '{d0, d1, d2, d3};
    len = eff_len(bl);
    i_targetAddr = a; i_burstLength = bl; i_readEnable = 1'b1;
    wait_accept(acc, ok);
    i_readEnable = 1'b0;
    if (ok) begin
      for (int k = 0; k < int'(len); k++) sb.push_back('{dv[k], acc + 1 + k + RL});
      tgt = acc + len + RL;
      while (cyc < tgt) @(negedge clk);
      check("busy_last_beat", {63'b0, o_busy}, 64'd1);
      @(negedge clk);
`ifndef PSX_DDR_RESP_STALL_EN
      check("busy_after_read", {63'b0, o_busy}, 64'd0);
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    bit ok;
    #2;
    check("rst_busy",  {63'b0, o_busy}, 64'd0);
    check("rst_valid", {63'b0, o_dataValid}, 64'd0);
    check("rst_data",  o_data, 64'd0);
    check("rst_err",   {63'b0, o_protocolError}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write then L=1 read: valid at T+3, busy low at T+4
    wbeat(17'h00010, 3'd1, DS, 8'hFF, 1'b0);
    rd(17'h00010, 3'd1, DS, 0, 0, 0);

    // 4-beat burst wrapping the top of memory
    wbeat(17'h1FFFE, 3'd4, D0, 8'hFF, 1'b0);
    wbeat(17'h00000, 3'd1, D1, 8'hFF, 1'b0);
    wbeat(17'h00000, 3'd1, D2, 8'hFF, 1'b0);
    wbeat(17'h00000, 3'd1, D3, 8'hFF, 1'b0);
    rd(17'h1FFFE, 3'd4, D0, D1, D2, D3);
    rd(17'h00000, 3'd2, D2, D3, 0, 0);

    // Byte-masked write
    wbeat(17'h00100, 3'd1, 64'd0, 8'hFF, 1'b0);
    wbeat(17'h00100, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0);
    rd(17'h00100, 3'd1, 64'h0000_0000_FFFF_FFFF, 0, 0, 0);
    check("err_clean", {63'b0, o_protocolError}, 64'd0);

    // Simultaneous read+write: write wins, read dropped, sticky error
    wbeat(17'h00020, 3'd1, 64'h55, 8'hFF, 1'b1);
    @(negedge clk);
`ifndef PSX_DDR_RESP_STALL_EN
    check("rw_no_read_busy", {63'b0, o_busy}, 64'd0);
`endif
    repeat (6) @(negedge clk);
    check("rw_err", {63'b0, o_protocolError}, 64'd1);
    @(posedge clk);
    #1;
    rd(17'h00020, 3'd1, 64'h55, 0, 0, 0);
    check("rw_err_sticky", {63'b0, o_protocolError}, 64'd1);

    // Reset after second beat of a 4-beat read
    i_targetAddr = 17'h1FFFE; i_burstLength = 3'd4; i_readEnable = 1'b1;
    wait_accept(acc, ok);
    i_readEnable = 1'b0;
    if (ok) begin
      sb.push_back('{D0, acc + 1 + RL});
      sb.push_back('{D1, acc + 2 + RL});
      while (cyc < acc + 2 + RL) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {63'b0, o_dataValid}, 64'd0);
      check("midrst_busy",  {63'b0, o_busy}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("midrst_err",   {63'b0, o_protocolError}, 64'd0);
      check("midrst_busy2", {63'b0, o_busy}, 64'd0);
      @(posedge clk);
      #1;
    end
    rd(17'h1FFFE, 3'd4, D0, D1, D2, D3);

    // Read request during a write burst is ignored but flagged
    wbeat(17'h00200, 3'd2, 64'hA5A5, 8'hFF, 1'b0);
    wbeat(17'h00000, 3'd1, 64'h5A5A, 8'hFF, 1'b1);
    repeat (6) @(negedge clk);
    check("wb_read_err", {63'b0, o_protocolError}, 64'd1);
    @(posedge clk);
    #1;
    rd(17'h00200, 3'd2, 64'hA5A5, 64'h5A5A, 0, 0);

    // Illegal burst lengths
    do_reset();
    rd(17'h00010, 3'd0, DS, 0, 0, 0);
    check("len0_err", {63'b0, o_protocolError}, 64'd1);
    rd(17'h1FFFE, 3'd7, D0, D1, D2, D3);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psx_ddr_mem_responder.md
# psx_ddr_mem_responder

Avalon-MM-style memory responder that sits on the DDR side of the PSX GPU memory bridge and services the 64-bit burst read/write traffic the bridge emits, from an on-chip 64-bit-wide memory. It stands in for the DDR controller in simulation and FPGA bring-up. It reproduces waitrequest stalls, fixed read latency and burst address sequencing, and flags protocol violations from the master.

## Interface
- `ADDR_W`, 17: word address width in 64-bit words; memory depth is 2^ADDR_W (default 1 MB).
- `READ_LATENCY`, 2: cycles from internal array read issue to data on `o_data`; legal range 1..8.
- `i_clk`  in  1  sole clock; everything is rising-edge.
- `i_nRst`  in  1  reset, asynchronous assert, active-low.
- `i_targetAddr`  in  ADDR_W  word address; sampled only on the first beat of a command.
- `i_burstLength`  in  3  beats, legal 1..4; sampled only on the first beat.
- `i_readEnable`  in  1  read command request.
- `i_writeEnable`  in  1  write beat request.
- `i_data`  in  64  write data.
- `i_byteEnable`  in  8  per-byte write enable; bit n covers `i_data[8n+7:8n]`.
- `o_busy`  out  1  waitrequest; a request is accepted only in a cycle where `o_busy` is 0.
- `o_dataValid`  out  1  read beat valid.
- `o_data`  out  64  read beat data.
- `o_protocolError`  out  1  sticky violation flag.

## Operation
- Effective length L: `i_burstLength` 0 maps to 1, 5..7 map to 4; either case sets the error flag.
- Beat k of a command targets `(base + k) mod 2^ADDR_W`, so the address wraps at the top of memory.
- The memory array is never reset. In simulation it is initialised to zero.
- States:
  - IDLE:
    - An accepted write with L=1 commits and stays in IDLE.
    - An accepted write with L>1 commits beat 0 and goes to WRITE_BURST with a beat counter of 1.
    - An accepted read goes to READ_ISSUE.
  - WRITE_BURST:
    - Each accepted `i_writeEnable` commits the next beat; address and length inputs are ignored.
    - After beat L-1 the state returns to IDLE.
  - READ_ISSUE:
    - Issues one array read per cycle for L cycles, then goes to READ_DRAIN.
  - READ_DRAIN:
    - Waits until the last beat leaves the latency pipeline, then returns to IDLE.
- Only one command is outstanding; there is no read pipelining across commands.
- Write commit is byte-masked: only bytes with `i_byteEnable` set change.
- Read-after-write to the same address always returns the new data.
- Error flag sets on any of:
  - `i_readEnable` and `i_writeEnable` both high in an accepting cycle. The write is performed and the read is dropped.
  - `i_readEnable` high in WRITE_BURST. The read is ignored.
  - An illegal burst length.
- `o_protocolError` clears only on reset.

## Timing
- Reset values:
  - `o_busy`=0, `o_dataValid`=0, `o_data`=0, `o_protocolError`=0.
  - State IDLE, latency pipeline empty.
- `o_busy`:
  - 0 in IDLE and WRITE_BURST, subject to the stall feature.
  - 1 in READ_ISSUE and READ_DRAIN.
- Read accepted at cycle T:
  - `o_busy`=1 from T+1.
  - Beat k has `o_dataValid`=1 in cycle T+1+k+READ_LATENCY. Beats are back-to-back with no gaps.
  - `o_busy` returns to 0 in the cycle after the last valid beat.
  - Example: default latency, L=1, accept at T=0 gives valid at cycle 3 and `o_busy`=0 at cycle 4.
- Write beat commit:
  - Takes effect at the accepting clock edge.
  - A read accepted the next cycle observes it.
- `o_data` holds its last value when `o_dataValid` is 0.
- Reset asserted mid-burst:
  - The pipeline flushes immediately and `o_dataValid` drops asynchronously.
  - Partially written bursts keep their committed beats.

## Configuration
- `PSX_DDR_RESP_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 at reset and advances every cycle.
  - When LFSR bits [1:0]==2'b11, `o_busy` is forced to 1 in IDLE and WRITE_BURST; no request is accepted that cycle.
- Undefined:
  - No LFSR is built.
  - IDLE and WRITE_BURST never stall.
  - All timing is exactly as stated above.

## Test plan
- Single write 64'h0123_4567_89AB_CDEF at 0x00010, byteEnable 8'hFF; then L=1 read at 0x00010 accepted at T -> `o_dataValid` only at T+3 with that data; `o_busy`=0 at T+4.
- 4-beat write of D0..D3 at base 0x1FFFE, then 4-beat read at 0x1FFFE -> four consecutive valid beats D0..D3. Words 0x00000/0x00001 hold D2/D3 (wrap).
- Write 64'hFFFF_FFFF_FFFF_FFFF with byteEnable 8'h0F over zeroed word 0x00100, then read -> 64'h0000_0000_FFFF_FFFF.
- Read and write both high in IDLE, addr 0x00020, data 64'h55 -> word holds 64'h55, no `o_dataValid` pulse, `o_protocolError`=1 until reset.
- Reset pulsed after second beat of a 4-beat read -> `o_dataValid`=0, `o_busy`=0 and error=0 after release; re-reading returns the original data.
- Read with `i_burstLength`=0 -> exactly one beat returned, `o_protocolError`=1; with `PSX_DDR_RESP_STALL_EN`, a 4-beat write completes intact under random stalls.
